// File: rtl/sipo_reg.sv
// Serial-in/parallel-out word register: MSB-first capture, framed by frame_start, gated by clk_inh.
// par_out updates one cycle after the last bit. No backpressure; an unacked word is overwritten and flags overrun.
module sipo_reg #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     N_clr,
  input  logic                     ser_in,
  input  logic                     clk_inh,
  input  logic                     frame_start,
  input  logic                     rd_ack,
  output logic [WIDTH-1:0]         par_out,
  output logic                     byte_valid,
  output logic                     data_full,
  output logic                     overrun,
  output logic                     q_ser,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] par_q,   par_d;
  logic             bv_q,    bv_d;
  logic             full_q,  full_d;
  logic             ovr_q,   ovr_d;

  logic             accept;
  logic             complete;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    accept   = ~clk_inh;
    shifted  = {shift_q[WIDTH-2:0], ser_in};
    // A frame_start bit always starts a new word, so it can never complete one.
    complete = accept & ~frame_start & (cnt_q == CNT_LAST);

    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (accept) begin
      shift_d = shifted;
      if (frame_start) begin
        cnt_d = CNT_ONE;
      end else if (complete) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    par_d = complete ? shifted : par_q;
    bv_d  = complete;

    full_d = full_q;
    if (complete) begin
      full_d = 1'b1;
    end else if (rd_ack) begin
      full_d = 1'b0;
    end

    // An ack arriving with the new word counts as having consumed the old one.
    ovr_d = ovr_q | (complete & full_q & ~rd_ack);
  end

  always_ff @(posedge clk) begin
    if (!N_clr) begin
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= '0;
      bv_q    <= 1'b0;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      bv_q    <= bv_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
    end
  end

  assign par_out    = par_q;
  assign byte_valid = bv_q;
  assign data_full  = full_q;
  assign overrun    = ovr_q;
  assign q_ser      = shift_q[WIDTH-1];
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_sipo_reg.sv
// Scenario bench for sipo_reg: expected words queued as bits are driven, captured words compared on byte_valid.
module tb_sipo_reg;

  logic       clk;
  logic       N_clr;
  logic       ser_in;
  logic       clk_inh;
  logic       frame_start;
  logic       rd_ack;
  logic [7:0] par_out;
  logic       byte_valid;
  logic       data_full;
  logic       overrun;
  logic       q_ser;
  logic [2:0] bit_cnt;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  sipo_reg #(.WIDTH(8)) dut (
    .clk        (clk),
    .N_clr      (N_clr),
    .ser_in     (ser_in),
    .clk_inh    (clk_inh),
    .frame_start(frame_start),
    .rd_ack     (rd_ack),
    .par_out    (par_out),
    .byte_valid (byte_valid),
    .data_full  (data_full),
    .overrun    (overrun),
    .q_ser      (q_ser),
    .bit_cnt    (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Drives one clock cycle from a negedge, observes at the following negedge.
  task automatic cycle(input logic s, input logic fs, input logic inh, input logic ack,
                       input logic rst_n = 1'b1);
    ser_in      = s;
    frame_start = fs;
    clk_inh     = inh;
    rd_ack      = ack;
    N_clr       = rst_n;
    @(posedge clk);
    @(negedge clk);
    if (byte_valid === 1'b1) begin
      got_q.push_back(par_out);
      pulse_cnt++;
    end
  endtask

  task automatic send_word(input logic [7:0] w, input logic fs, input logic ack_last);
    exp_q.push_back(w);
    for (int i = 7; i >= 0; i--)
      cycle(w[i], fs && (i == 7), 1'b0, ack_last && (i == 0));
  endtask

  task automatic test_reset;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (par_out !== 8'h00) begin errors++; $display("FAIL reset_par_out got=%h exp=00", par_out); end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_byte_valid got=%b exp=0", byte_valid); end
    checks++; if (data_full !== 1'b0) begin errors++; $display("FAIL reset_data_full got=%b exp=0", data_full); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (q_ser !== 1'b0) begin errors++; $display("FAIL reset_q_ser got=%b exp=0", q_ser); end
    checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt); end
  endtask

  task automatic test_basic;
    logic [7:0] w;
    logic [7:0] g;
    logic [7:0] e;
    int p0;
    w  = 8'hA5;
    p0 = pulse_cnt;
    exp_q.push_back(w);
    cycle(w[7], 1'b1, 1'b0, 1'b0);
    checks++; if (bit_cnt !== 3'd1) begin errors++; $display("FAIL basic_cnt_after_fs got=%0d exp=1", bit_cnt); end
    for (int i = 6; i >= 0; i--) cycle(w[i], 1'b0, 1'b0, 1'b0);
    checks++; if (byte_valid !== 1'b1) begin errors++; $display("FAIL basic_byte_valid got=%b exp=1", byte_valid); end
    checks++; if (data_full !== 1'b1) begin errors++; $display("FAIL basic_data_full got=%b exp=1", data_full); end
    checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL basic_bit_cnt got=%0d exp=0", bit_cnt); end
    checks++;
    if (got_q.size() == 0) begin errors++; $display("FAIL basic_word got=none exp=%h", w); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) begin errors++; $display("FAIL basic_word got=%h exp=%h", g, e); end
    end
    // Inhibited cycle: pulse must drop, ack must still be honoured.
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got=%b exp=0", byte_valid); end
    checks++; if (data_full !== 1'b0) begin errors++; $display("FAIL basic_ack_inhibited got=%b exp=0", data_full); end
    checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL basic_inh_cnt got=%0d exp=0", bit_cnt); end
    checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL basic_pulses got=%0d exp=1", pulse_cnt - p0); end
  endtask

  task automatic test_inhibit;
    logic [7:0] w;
    logic [7:0] g;
    logic [7:0] e;
    logic       qs;
    int p0;
    w  = 8'h3C;
    p0 = pulse_cnt;
    exp_q.push_back(w);
    for (int i = 7; i >= 4; i--) cycle(w[i], i == 7, 1'b0, 1'b0);
    checks++; if (bit_cnt !== 3'd4) begin errors++; $display("FAIL inh_cnt_before got=%0d exp=4", bit_cnt); end
    qs = q_ser;
    for (int k = 0; k < 3; k++) begin
      cycle(k[0], 1'b1, 1'b1, 1'b0);
      checks++; if (bit_cnt !== 3'd4) begin errors++; $display("FAIL inh_cnt_hold[%0d] got=%0d exp=4", k, bit_cnt); end
      checks++; if (q_ser !== qs) begin errors++; $display("FAIL inh_q_ser_hold[%0d] got=%b exp=%b", k, q_ser, qs); end
      checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL inh_no_pulse[%0d] got=%b exp=0", k, byte_valid); end
    end
    for (int i = 3; i >= 0; i--) cycle(w[i], 1'b0, 1'b0, 1'b0);
    checks++; if (par_out !== 8'h3C) begin errors++; $display("FAIL inh_par_out got=%h exp=3c", par_out); end
    checks++;
    if (got_q.size() == 0) begin errors++; $display("FAIL inh_word got=none exp=%h", w); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) begin errors++; $display("FAIL inh_word got=%h exp=%h", g, e); end
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL inh_pulses got=%0d exp=1", pulse_cnt - p0); end
  endtask

  task automatic test_back_to_back_overrun;
    logic [7:0] g;
    logic [7:0] e;
    int p0;
    p0 = pulse_cnt;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_initial got=%b exp=0", overrun); end
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    checks++; if (par_out !== 8'h22) begin errors++; $display("FAIL ovr_par_out got=%h exp=22", par_out); end
    checks++; if (pulse_cnt - p0 !== 2) begin errors++; $display("FAIL ovr_pulses got=%0d exp=2", pulse_cnt - p0); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL ovr_word[%0d] got=none", k); end
      else begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL ovr_word[%0d] got=%h exp=%h", k, g, e); end
      end
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (data_full !== 1'b0) begin errors++; $display("FAIL ovr_ack_full got=%b exp=0", data_full); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky2 got=%b exp=1", overrun); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_cleared_by_reset got=%b exp=0", overrun); end
  endtask

  task automatic test_ack_coincide;
    logic [7:0] g;
    logic [7:0] e;
    send_word(8'hF0, 1'b1, 1'b0);
    send_word(8'h0F, 1'b0, 1'b1);
    checks++; if (data_full !== 1'b1) begin errors++; $display("FAIL coin_data_full got=%b exp=1", data_full); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL coin_overrun got=%b exp=0", overrun); end
    checks++; if (par_out !== 8'h0F) begin errors++; $display("FAIL coin_par_out got=%h exp=0f", par_out); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL coin_word[%0d] got=none", k); end
      else begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL coin_word[%0d] got=%h exp=%h", k, g, e); end
      end
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_resync;
    logic [7:0] g;
    logic [7:0] e;
    logic [4:0] junk;
    int p0;
    junk = 5'b10110;
    p0   = pulse_cnt;
    for (int i = 4; i >= 0; i--) cycle(junk[i], 1'b0, 1'b0, 1'b0);
    checks++; if (bit_cnt !== 3'd5) begin errors++; $display("FAIL resync_partial_cnt got=%0d exp=5", bit_cnt); end
    send_word(8'h81, 1'b1, 1'b0);
    checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL resync_pulses got=%0d exp=1", pulse_cnt - p0); end
    checks++; if (par_out !== 8'h81) begin errors++; $display("FAIL resync_par_out got=%h exp=81", par_out); end
    checks++;
    if (got_q.size() == 0) begin errors++; $display("FAIL resync_word got=none exp=81"); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) begin errors++; $display("FAIL resync_word got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_reset_midword;
    logic [7:0] g;
    logic [7:0] e;
    logic [7:0] w;
    int p0;
    w = 8'h5A;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (par_out !== 8'h00) begin errors++; $display("FAIL rstmid_par_out got=%h exp=00", par_out); end
    checks++; if (data_full !== 1'b0) begin errors++; $display("FAIL rstmid_data_full got=%b exp=0", data_full); end
    checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL rstmid_bit_cnt got=%0d exp=0", bit_cnt); end
    checks++; if (q_ser !== 1'b0) begin errors++; $display("FAIL rstmid_q_ser got=%b exp=0", q_ser); end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL rstmid_byte_valid got=%b exp=0", byte_valid); end
    p0 = pulse_cnt;
    exp_q.push_back(w);
    cycle(w[7], 1'b0, 1'b0, 1'b0);
    checks++; if (bit_cnt !== 3'd1) begin errors++; $display("FAIL rstmid_first_bit_cnt got=%0d exp=1", bit_cnt); end
    for (int i = 6; i >= 0; i--) cycle(w[i], 1'b0, 1'b0, 1'b0);
    checks++; if (par_out !== 8'h5A) begin errors++; $display("FAIL rstmid_word_par_out got=%h exp=5a", par_out); end
    checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL rstmid_pulses got=%0d exp=1", pulse_cnt - p0); end
    checks++;
    if (got_q.size() == 0) begin errors++; $display("FAIL rstmid_word got=none exp=5a"); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) begin errors++; $display("FAIL rstmid_word got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_drain;
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL drain_unexpected_words got=%0d exp=0", got_q.size()); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain_missing_words got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    N_clr = 1'b0; ser_in = 1'b0; clk_inh = 1'b0; frame_start = 1'b0; rd_ack = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_inhibit;
    test_back_to_back_overrun;
    test_ack_coincide;
    test_resync;
    test_reset_midword;
    test_drain;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_reg.md
SIPO_REG -- requirements
Module: sipo_reg

Interface
REQ-001 Parameter: WIDTH, 8, word length in bits; legal range 2..32.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: N_clr  in  1  reset, synchronous and active-low.
REQ-004 Port: ser_in  in  1  serial data, MSB of each word first.
REQ-005 Port: clk_inh  in  1  clock inhibit; high = shift path frozen.
REQ-006 Port: frame_start  in  1  marks the current ser_in bit as the MSB of a new word.
REQ-007 Port: rd_ack  in  1  consumer has taken par_out; clears data_full.
REQ-008 Port: par_out  out  WIDTH  last completed word, registered.
REQ-009 Port: byte_valid  out  1  one-cycle pulse when par_out is updated.
REQ-010 Port: data_full  out  1  an unacknowledged word is held in par_out.
REQ-011 Port: overrun  out  1  sticky; a word completed while data_full was set and not acked.
REQ-012 Port: q_ser  out  1  equals shift_reg[WIDTH-1], the cascade output.
REQ-013 Port: bit_cnt  out  clog2(WIDTH)  bits received in the current word.

Function
REQ-014 Accepted cycle: N_clr=1 and clk_inh=0; only accepted cycles sample ser_in.
REQ-015 On an accepted cycle, shift_reg <= {shift_reg[WIDTH-2:0], ser_in} (shift toward MSB, new bit at bit 0).
REQ-016 On an accepted cycle with frame_start=1, bit_cnt <= 1 and the partial word is discarded; no completion occurs that cycle.
REQ-017 On an accepted cycle with frame_start=0, bit_cnt increments; when bit_cnt==WIDTH-1, it wraps to 0 and the word completes.
REQ-018 On completion, par_out <= {shift_reg[WIDTH-2:0], ser_in}, byte_valid=1 and data_full=1 in the next cycle (1-cycle latency from the last bit edge).
REQ-019 byte_valid is high for exactly one cycle per completed word; it is low on every other cycle, including inhibited cycles.
REQ-020 If rd_ack=1 and there is no completion, data_full <= 0; rd_ack while data_full=0 has no effect.
REQ-021 If a completion and rd_ack coincide, data_full stays 1 and overrun is not set.
REQ-022 If a completion occurs with data_full=1 and rd_ack=0, par_out is overwritten with the new word and overrun <= 1; overrun stays set until reset.
REQ-023 When clk_inh=1: shift_reg, bit_cnt and q_ser hold, frame_start is ignored, and rd_ack is still honoured.
REQ-024 Back-to-back words with no idle bits are supported; the next word's MSB is sampled on the cycle after completion.

Reset
REQ-025 While N_clr=0 at a clock edge: shift_reg=0, bit_cnt=0, par_out=0, byte_valid=0, data_full=0, overrun=0, q_ser=0; this takes priority over all other inputs.
REQ-026 Reset asserted mid-word discards the partial word; the first accepted bit after release is bit 1 of a new word, with or without frame_start.

Verification
REQ-027 Reset, then frame_start with bit 1, then bits of 0xA5 MSB-first over 8 accepted cycles -> next cycle par_out=0xA5, byte_valid one pulse, data_full=1, bit_cnt=0.
REQ-028 Send 0x3C with clk_inh=1 for 3 cycles after bit 4 -> bit_cnt holds at 4, q_ser is stable, final par_out=0x3C, single byte_valid pulse.
REQ-029 Send 0x11 (no ack), then 0x22 -> overrun=1, par_out=0x22; rd_ack -> data_full=0, overrun still 1 until N_clr=0.
REQ-030 Send 0xF0 with rd_ack pulsed on the completion cycle of a second word 0x0F -> data_full=1, overrun=0, par_out=0x0F.
REQ-031 Send 5 bits, then frame_start and 8 bits of 0x81 -> the partial word is discarded, exactly one byte_valid, par_out=0x81.
REQ-032 N_clr=0 for 1 cycle after 6 bits, then 8 bits of 0x5A -> all outputs 0 after reset, then par_out=0x5A after the 8th bit.
